// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bridge: FSM state codes,
// command-word field helpers and default parameter values.
package spi_pkg;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_MSB_FIRST = 1;

    // Frame FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_CMD     = 2'd0;
    localparam state_t ST_WR_DATA = 2'd1;
    localparam state_t ST_RD_DATA = 2'd2;
    localparam state_t ST_DISCARD = 2'd3;

    // The R/W flag is the top bit of the command word (1 = write, 0 = read)
    function automatic int rw_bit_pos(input int word_w);
        return word_w - 1;
    endfunction

endpackage

// File: rtl/spi_shift_core.sv
// Bit-level SPI engine: bit counter, RX shift register (rising edge),
// TX shift register (falling edge) and word-done detection.
// Word 0 transmits the status word; every later word transmits load_word,
// captured on the falling edge that starts the word.
module spi_shift_core
    import spi_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              sclk,
    input  logic              frame_rst_n,
    input  logic              mosi,
    input  logic [WORD_W-1:0] status,
    input  logic [WORD_W-1:0] load_word,
    output logic              last_bit,
    output logic [WORD_W-1:0] rx_word,
    output logic              tx_bit
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_sr;
    logic [WORD_W-1:0] tx_sr;
    logic              tx_live;

    function automatic logic head(input logic [WORD_W-1:0] v);
        return (MSB_FIRST != 0) ? v[WORD_W-1] : v[0];
    endfunction

    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[WORD_W-2:0], 1'b0} : {1'b0, v[WORD_W-1:1]};
    endfunction

    assign last_bit = (bit_cnt == CNT_LAST);
    assign rx_word  = (MSB_FIRST != 0) ? {rx_sr[WORD_W-2:0], mosi}
                                       : {mosi, rx_sr[WORD_W-1:1]};

    // Until the first falling edge of a frame, the first status bit goes out
    // directly so it is valid before the first rising edge.
    assign tx_bit = tx_live ? head(tx_sr) : head(status);

    // Receive side: count bits and assemble the incoming word
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
        end else begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            rx_sr   <= rx_word;
        end
    end

    // Transmit side: shift on falling edges, reload at each word boundary
    always_ff @(negedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            tx_live <= 1'b0;
            tx_sr   <= '0;
        end else if (!tx_live) begin
            tx_live <= 1'b1;
            tx_sr   <= advance(status);
        end else if (bit_cnt == '0) begin
            tx_sr   <= load_word;
        end else begin
            tx_sr   <= advance(tx_sr);
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) to register-bank bridge. Word 0 of a frame is a command
// (R/W flag + start address) while the status word {ovf, frame_cnt} is
// returned; later words are burst writes or burst reads with address
// auto-increment. Writes are handed to the clk-domain via a toggle.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_tgl,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              ovf
);

    localparam int RW_BIT = rw_bit_pos(WORD_W);
    localparam int FCNT_W = WORD_W - 1;
    localparam int WCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [WCNT_W-1:0] BURST_FULL = WCNT_W'(MAX_BURST);

    logic              frame_rst_n;
    state_t            state;
    logic [WCNT_W-1:0] word_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [FCNT_W-1:0] frame_cnt;
    logic              last_bit;
    logic [WORD_W-1:0] rx_word;
    logic              tx_bit;
    logic              cmd_done;
    logic              data_done;
    logic              burst_full;
    logic              ovf_hit;
    logic              wr_hit;
    logic              rd_hit;

    // Frame-scoped logic is held clear while cs_n is high (or in reset)
    assign frame_rst_n = rst_n & ~cs_n;

    spi_shift_core #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .sclk        (sclk),
        .frame_rst_n (frame_rst_n),
        .mosi        (mosi),
        .status      ({ovf, frame_cnt}),
        .load_word   (rd_data),
        .last_bit    (last_bit),
        .rx_word     (rx_word),
        .tx_bit      (tx_bit)
    );

    assign cmd_done   = last_bit && (state == ST_CMD);
    assign data_done  = last_bit && ((state == ST_WR_DATA) || (state == ST_RD_DATA));
    assign burst_full = (word_cnt == BURST_FULL);
    assign ovf_hit    = data_done && burst_full;
    assign wr_hit     = data_done && !burst_full && (state == ST_WR_DATA);
    assign rd_hit     = data_done && !burst_full && (state == ST_RD_DATA);

    assign miso = ~cs_n & (state != ST_DISCARD) & tx_bit;

    // Per-frame control: FSM and completed data-word count
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state    <= ST_CMD;
            word_cnt <= '0;
        end else begin
            if (cmd_done) begin
                state <= rx_word[RW_BIT] ? ST_WR_DATA : ST_RD_DATA;
            end else if (ovf_hit) begin
                state <= ST_DISCARD;
            end
            if (wr_hit || rd_hit) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end
        end
    end

    // Persistent outputs: survive cs_n, cleared only by rst_n
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_tgl    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
            cur_addr  <= '0;
        end else begin
            if (cmd_done) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
                cur_addr  <= rx_word[ADDR_W-1:0];
                if (!rx_word[RW_BIT]) begin
                    rd_addr <= rx_word[ADDR_W-1:0];
                end
            end
            if (wr_hit) begin
                wr_addr  <= cur_addr;
                wr_data  <= rx_word;
                wr_tgl   <= ~wr_tgl;
                cur_addr <= cur_addr + ADDR_W'(1);
            end
            if (rd_hit) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                rd_addr  <= cur_addr + ADDR_W'(1);
            end
            if (ovf_hit) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge (8-bit words, 6-bit address,
// burst limit 2). Directed frames followed by random frames, all checked
// against a frame-level reference model.
module tb_spi_reg_bridge;

    localparam int HALF = 5;
    localparam int MAXB = 2;

    logic       sclk;
    logic       rst_n;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       wr_tgl;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       ovf;

    logic [7:0] regs [64];
    logic [7:0] fw   [8];

    // reference model state
    logic       m_ovf;
    logic [6:0] m_fcnt;
    logic       m_tgl;

    int n_total = 0;
    int n_bad   = 0;

    assign rd_data = regs[rd_addr];

    spi_reg_bridge #(
        .WORD_W    (8),
        .ADDR_W    (6),
        .MAX_BURST (MAXB),
        .MSB_FIRST (1)
    ) dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .wr_tgl  (wr_tgl),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .ovf     (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_wr_tgl"}, wr_tgl, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    // Shift nbits of w (MSB first); miso is sampled half a period after the
    // falling edge, just before the rising edge.
    task automatic xfer_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = w[i];
            #HALF;
            got[i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    // Run one frame: fw[0..n-1] full words, then 'part' bits of fw[n]
    task automatic do_frame(input int n, input int part);
        logic [7:0] got;
        logic [7:0] exp_st;
        logic       is_wr;
        logic [5:0] start;
        logic [5:0] a;
        int         done_words;
        exp_st = {m_ovf, m_fcnt};
        is_wr  = fw[0][7];
        start  = fw[0][5:0];
        cs_n   = 1'b0;
        #HALF;
        for (int k = 0; k < n; k++) begin
            xfer_bits(fw[k], 8, got);
            if (k == 0) begin
                chk("status", got, exp_st);
                m_fcnt = m_fcnt + 7'd1;
            end else begin
                a = start + 6'(k - 1);
                if (k - 1 < MAXB) begin
                    if (is_wr) begin
                        m_tgl = ~m_tgl;
                        chk("wr_addr", wr_addr, a);
                        chk("wr_data", wr_data, fw[k]);
                    end else begin
                        chk("rd_word", got, regs[a]);
                    end
                end else begin
                    m_ovf = 1'b1;
                    if (k - 1 > MAXB) chk("discard_miso", got, 0);
                end
                chk("wr_tgl", wr_tgl, m_tgl);
            end
        end
        if (part > 0) xfer_bits(fw[n], part, got);
        cs_n = 1'b1;
        mosi = 1'b0;
        #HALF;
        chk("idle_miso", miso, 0);
        chk("tgl_after_frame", wr_tgl, m_tgl);
        chk("ovf", ovf, m_ovf);
        if (!is_wr && n > 0) begin
            done_words = (n - 1 < MAXB) ? n - 1 : MAXB;
            chk("rd_addr_end", rd_addr, 6'(start + 6'(done_words)));
        end
        #HALF;
    endtask

    task automatic model_reset();
        m_ovf  = 1'b0;
        m_fcnt = 7'd0;
        m_tgl  = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int nd;
        int part;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) regs[i] = 8'(i + 8'h40);
        model_reset();
        #(4 * HALF);
        chk_reset_state("reset");
        rst_n = 1'b1;
        #(2 * HALF);

        // write burst
        fw[0] = 8'h85; fw[1] = 8'hAA; fw[2] = 8'h55;
        do_frame(3, 0);
        // read burst, rd_data = rd_addr + 0x40
        fw[0] = 8'h10; fw[1] = 8'h00; fw[2] = 8'h00;
        do_frame(3, 0);
        // address wrap
        fw[0] = 8'hBF; fw[1] = 8'h11; fw[2] = 8'h22;
        do_frame(3, 0);
        // abort after 5 bits of first data word, then a clean write
        fw[0] = 8'h81; fw[1] = 8'hC3;
        do_frame(1, 5);
        fw[0] = 8'h81; fw[1] = 8'h7E;
        do_frame(2, 0);
        // overflow: 3 data words with a burst limit of 2
        fw[0] = 8'h8A; fw[1] = 8'h01; fw[2] = 8'h02; fw[3] = 8'h03;
        do_frame(4, 0);
        // read frame after overflow: status MSB set, extra words read as 0
        fw[0] = 8'h20; fw[1] = 8'h00; fw[2] = 8'h00; fw[3] = 8'h00; fw[4] = 8'h00;
        do_frame(5, 0);

        // reset in the middle of a command word
        cs_n = 1'b0;
        #HALF;
        xfer_bits(8'h82, 3, got);
        rst_n = 1'b0;
        #HALF;
        chk_reset_state("midreset");
        model_reset();
        cs_n = 1'b1;
        #HALF;
        rst_n = 1'b1;
        #(2 * HALF);
        fw[0] = 8'h82; fw[1] = 8'h33;
        do_frame(2, 0);

        // random frames (enough to wrap the 7-bit frame counter)
        for (int f = 0; f < 140; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 64; i++) regs[i] = 8'($urandom);
            end
            nd    = $urandom_range(0, 4);
            fw[0] = 8'($urandom);
            for (int k = 1; k <= 5; k++) fw[k] = 8'($urandom);
            part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            do_frame(nd + 1, part);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
